// File: rtl/dut_arb_pkg.sv
// Shared sizing and the channel-index type for the two-channel DUT port arbiter.
package dut_arb_pkg;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 3;
  typedef logic ch_idx_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_arb2
  import dut_arb_pkg::*;
(
  input  logic [1:0] req,
  input  ch_idx_t    last,
  output ch_idx_t    gnt,
  output logic       any
);
  assign any = |req;
  assign gnt = (&req) ? ~last : req[1];
endmodule

// File: rtl/dut_port_arbiter.sv
// Arbitrates two requester channels onto one DUT write port and one DUT read port,
// each channel holding a one-entry write buffer and a one-entry read buffer.
module dut_port_arbiter
  import dut_arb_pkg::*;
#(
  parameter int NUM_CH = dut_arb_pkg::NUM_CH,
  parameter int ADDR_W = dut_arb_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_wr_valid,
  output logic [NUM_CH-1:0]        ch_wr_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_wr_addr,
  input  logic [NUM_CH-1:0]        ch_wr_data,
  input  logic [NUM_CH-1:0]        ch_rd_valid,
  output logic [NUM_CH-1:0]        ch_rd_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_rd_addr,
  output logic [NUM_CH-1:0]        ch_rsp_valid,
  output logic [NUM_CH-1:0]        ch_rsp_data,
  output logic [ADDR_W-1:0]        write_addr,
  output logic                     write_data,
  output logic                     write_en,
  input  logic                     write_ready,
  output logic [ADDR_W-1:0]        read_addr,
  output logic                     read_en,
  input  logic                     read_data,
  input  logic                     read_ready
);
  logic [NUM_CH-1:0]             wbuf_full, rbuf_full;
  logic [NUM_CH-1:0][ADDR_W-1:0] wbuf_addr, rbuf_addr;
  logic [NUM_CH-1:0]             wbuf_data;
  ch_idx_t                       wr_gnt, rd_gnt, wr_last, rd_last;
  logic                          wr_any, rd_any;

  rr_arb2 u_wr_arb (.req(wbuf_full), .last(wr_last), .gnt(wr_gnt), .any(wr_any));
  rr_arb2 u_rd_arb (.req(rbuf_full), .last(rd_last), .gnt(rd_gnt), .any(rd_any));

  assign write_en   = wr_any & write_ready;
  assign write_addr = wr_any ? wbuf_addr[wr_gnt] : '0;
  assign write_data = wr_any ? wbuf_data[wr_gnt] : 1'b0;
  assign read_en    = rd_any & read_ready;
  assign read_addr  = rd_any ? rbuf_addr[rd_gnt] : '0;

  // Ready is the registered empty flag, so a buffer draining this cycle cannot refill at the same edge.
  assign ch_wr_ready = ~wbuf_full;
  assign ch_rd_ready = ~rbuf_full;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic              wr_take, wr_clr, rd_take, rd_clr;
    logic              wfull_q, wdata_q, rfull_q;
    logic [ADDR_W-1:0] waddr_q, raddr_q;

    assign wr_take = ch_wr_valid[i] & ~wfull_q;
    assign wr_clr  = write_en & (wr_gnt == ch_idx_t'(i));
    assign rd_take = ch_rd_valid[i] & ~rfull_q;
    assign rd_clr  = read_en & (rd_gnt == ch_idx_t'(i));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wfull_q <= 1'b0;
        waddr_q <= '0;
        wdata_q <= 1'b0;
        rfull_q <= 1'b0;
        raddr_q <= '0;
      end else begin
        if (wr_take) begin
          wfull_q <= 1'b1;
          waddr_q <= ch_wr_addr[i*ADDR_W +: ADDR_W];
          wdata_q <= ch_wr_data[i];
        end else if (wr_clr) begin
          wfull_q <= 1'b0;
        end
        if (rd_take) begin
          rfull_q <= 1'b1;
          raddr_q <= ch_rd_addr[i*ADDR_W +: ADDR_W];
        end else if (rd_clr) begin
          rfull_q <= 1'b0;
        end
      end
    end

    assign wbuf_full[i] = wfull_q;
    assign wbuf_addr[i] = waddr_q;
    assign wbuf_data[i] = wdata_q;
    assign rbuf_full[i] = rfull_q;
    assign rbuf_addr[i] = raddr_q;
  end

  // Last pointers start at 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_last      <= 1'b1;
      rd_last      <= 1'b1;
      ch_rsp_valid <= '0;
      ch_rsp_data  <= '0;
    end else begin
      ch_rsp_valid <= '0;
      if (write_en) wr_last <= wr_gnt;
      if (read_en) begin
        rd_last              <= rd_gnt;
        ch_rsp_valid[rd_gnt] <= 1'b1;
        ch_rsp_data[rd_gnt]  <= read_data;
      end
    end
  end
endmodule

// File: tb/tb_dut_port_arbiter.sv
// Randomized and directed bench for dut_port_arbiter against a transaction-level reference model.
module tb_dut_port_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ch_wr_valid = '0, ch_wr_ready, ch_wr_data = '0;
  logic [5:0] ch_wr_addr = '0, ch_rd_addr = '0;
  logic [1:0] ch_rd_valid = '0, ch_rd_ready, ch_rsp_valid, ch_rsp_data;
  logic [2:0] write_addr, read_addr;
  logic       write_data, write_en, write_ready = 1'b0;
  logic       read_en, read_data = 1'b0, read_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  dut_port_arbiter dut (
    .clk(clk), .reset(reset),
    .ch_wr_valid(ch_wr_valid), .ch_wr_ready(ch_wr_ready), .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data),
    .ch_rd_valid(ch_rd_valid), .ch_rd_ready(ch_rd_ready), .ch_rd_addr(ch_rd_addr),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en), .write_ready(write_ready),
    .read_addr(read_addr), .read_en(read_en), .read_data(read_data), .read_ready(read_ready)
  );

  always #5 clk = ~clk;

  // Reference model: each channel holds at most one pending write and one pending read.
  bit       pw[2], pr[2];
  bit [2:0] pw_addr[2], pr_addr[2];
  bit       pw_data[2];
  int       served_w, served_r;
  bit [1:0] m_rsp_v, m_rsp_d;
  int       e_wg, e_rg;
  bit       e_wen, e_ren, e_wd;
  bit [2:0] e_wa, e_ra;

  function automatic int choose(bit a, bit b, int last_served);
    if (a && b) return 1 - last_served;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pw[i] = 0; pr[i] = 0; pw_addr[i] = 0; pr_addr[i] = 0; pw_data[i] = 0;
    end
    served_w = 1; served_r = 1; m_rsp_v = 0; m_rsp_d = 0;
  endtask

  task automatic model_eval();
    e_wg  = choose(pw[0], pw[1], served_w);
    e_rg  = choose(pr[0], pr[1], served_r);
    e_wen = (e_wg >= 0) && write_ready;
    e_ren = (e_rg >= 0) && read_ready;
    e_wa  = (e_wg >= 0) ? pw_addr[e_wg] : 3'd0;
    e_wd  = (e_wg >= 0) ? pw_data[e_wg] : 1'b0;
    e_ra  = (e_rg >= 0) ? pr_addr[e_rg] : 3'd0;
  endtask

  task automatic model_advance();
    bit       acc_w[2], acc_r[2];
    bit [5:0] wa, ra;
    model_eval();
    wa = ch_wr_addr; ra = ch_rd_addr;
    for (int i = 0; i < 2; i++) begin
      acc_w[i] = ch_wr_valid[i] && !pw[i];
      acc_r[i] = ch_rd_valid[i] && !pr[i];
    end
    m_rsp_v = 0;
    if (e_wen) begin pw[e_wg] = 0; served_w = e_wg; end
    if (e_ren) begin
      pr[e_rg] = 0; served_r = e_rg;
      m_rsp_v[e_rg] = 1; m_rsp_d[e_rg] = read_data;
    end
    for (int i = 0; i < 2; i++) begin
      if (acc_w[i]) begin pw[i] = 1; pw_addr[i] = wa[i*3 +: 3]; pw_data[i] = ch_wr_data[i]; end
      if (acc_r[i]) begin pr[i] = 1; pr_addr[i] = ra[i*3 +: 3]; end
    end
  endtask

  task automatic tick();
    if (reset) model_reset(); else model_advance();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    ch_wr_valid = 0; ch_rd_valid = 0; ch_wr_addr = 0; ch_rd_addr = 0; ch_wr_data = 0;
    write_ready = 0; read_ready = 0; read_data = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1; model_reset();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; model_reset();
    ch_wr_valid = 2'b11; ch_rd_valid = 2'b11; write_ready = 1; read_ready = 1;
    ch_wr_addr = 6'h3f; ch_rd_addr = 6'h2d; ch_wr_data = 2'b11; read_data = 1;
    #1;
    checks++; if ({ch_wr_ready, ch_rd_ready} !== 4'b1111) begin errors++;
      $display("FAIL reset_ready: got wr=%b rd=%b want 11/11", ch_wr_ready, ch_rd_ready); end
    checks++; if ({write_en, read_en, ch_rsp_valid, ch_rsp_data} !== 6'b0) begin errors++;
      $display("FAIL reset_strobes: got wen=%b ren=%b rv=%b rd=%b want all 0", write_en, read_en, ch_rsp_valid, ch_rsp_data); end
    checks++; if ({write_addr, write_data, read_addr} !== 7'b0) begin errors++;
      $display("FAIL reset_port: got wa=%0d wd=%b ra=%0d want 0", write_addr, write_data, read_addr); end
    tick();
    drive_idle();
    reset = 0;
  endtask

  task automatic test_single_write();
    do_reset();
    ch_wr_valid = 2'b01; ch_wr_addr = {3'd0, 3'd4}; ch_wr_data = 2'b01; write_ready = 1;
    tick();
    ch_wr_valid = 0;
    #1;
    checks++; if ({write_en, write_addr, write_data} !== {1'b1, 3'd4, 1'b1}) begin errors++;
      $display("FAIL single_write_issue: got en=%b a=%0d d=%b want 1/4/1", write_en, write_addr, write_data); end
    checks++; if (ch_wr_ready !== 2'b10) begin errors++;
      $display("FAIL single_write_ready: got %b want 10", ch_wr_ready); end
    tick(); #1;
    checks++; if ({write_en, write_addr, write_data} !== 5'b0) begin errors++;
      $display("FAIL single_write_after: got en=%b a=%0d d=%b want 0/0/0", write_en, write_addr, write_data); end
  endtask

  task automatic test_alternate();
    do_reset();
    ch_wr_valid = 2'b11; ch_wr_addr = {3'd5, 3'd4}; ch_wr_data = 2'b01; write_ready = 1;
    tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if ({write_en, write_addr, write_data} !== ((k % 2) ? {1'b1, 3'd5, 1'b0} : {1'b1, 3'd4, 1'b1})) begin errors++;
        $display("FAIL alternate_grant%0d: got en=%b a=%0d d=%b want ch%0d", k, write_en, write_addr, write_data, k % 2); end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_wr_valid = 2'b11; ch_wr_addr = {3'd5, 3'd4}; ch_wr_data = 2'b01; write_ready = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if ({write_en, ch_wr_ready} !== 3'b000) begin errors++;
        $display("FAIL backpressure_hold%0d: got en=%b ready=%b want 0/00", k, write_en, ch_wr_ready); end
      tick();
    end
    write_ready = 1; #1;
    checks++; if ({write_en, write_addr} !== {1'b1, 3'd4}) begin errors++;
      $display("FAIL backpressure_release: got en=%b a=%0d want 1/4", write_en, write_addr); end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_read();
    do_reset();
    ch_rd_valid = 2'b10; ch_rd_addr = {3'd3, 3'd0}; read_ready = 1; read_data = 1;
    tick();
    ch_rd_valid = 0; #1;
    checks++; if ({read_en, read_addr, ch_rsp_valid} !== {1'b1, 3'd3, 2'b00}) begin errors++;
      $display("FAIL read_issue: got en=%b a=%0d rv=%b want 1/3/00", read_en, read_addr, ch_rsp_valid); end
    tick(); read_data = 0; #1;
    checks++; if ({ch_rsp_valid, ch_rsp_data[1], read_en} !== {2'b10, 1'b1, 1'b0}) begin errors++;
      $display("FAIL read_rsp: got rv=%b rd1=%b en=%b want 10/1/0", ch_rsp_valid, ch_rsp_data[1], read_en); end
    tick(); #1;
    checks++; if ({ch_rsp_valid, ch_rsp_data[1]} !== {2'b00, 1'b1}) begin errors++;
      $display("FAIL read_rsp_hold: got rv=%b rd1=%b want 00/1", ch_rsp_valid, ch_rsp_data[1]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_wr_valid = 2'b11; ch_wr_addr = {3'd2, 3'd6}; ch_wr_data = 2'b10; write_ready = 0;
    tick(); #1;
    checks++; if (ch_wr_ready !== 2'b00) begin errors++;
      $display("FAIL reset_mid_full: got %b want 00", ch_wr_ready); end
    reset = 1; model_reset(); ch_wr_valid = 0; #1;
    checks++; if ({ch_wr_ready, write_en} !== 3'b110) begin errors++;
      $display("FAIL reset_mid_clear: got ready=%b en=%b want 11/0", ch_wr_ready, write_en); end
    tick();
    reset = 0; write_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({write_en, ch_wr_ready} !== 3'b011) begin errors++;
        $display("FAIL reset_mid_after%0d: got en=%b ready=%b want 0/11", k, write_en, ch_wr_ready); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ch_wr_valid = 2'($urandom); ch_rd_valid = 2'($urandom);
      ch_wr_addr  = 6'($urandom); ch_rd_addr  = 6'($urandom); ch_wr_data = 2'($urandom);
      write_ready = ($urandom_range(0, 3) != 0); read_ready = ($urandom_range(0, 3) != 0);
      read_data   = 1'($urandom);
      reset       = ($urandom_range(0, 79) == 0);
      if (reset) model_reset();
      #1;
      model_eval();
      checks++; if ({ch_wr_ready, write_en, write_addr, write_data} !== {~pw[1], ~pw[0], e_wen, e_wa, e_wd}) begin errors++;
        $display("FAIL rand_write%0d: got rdy=%b en=%b a=%0d d=%b want rdy=%b%b en=%b a=%0d d=%b", k,
                 ch_wr_ready, write_en, write_addr, write_data, ~pw[1], ~pw[0], e_wen, e_wa, e_wd); end
      checks++; if ({ch_rd_ready, read_en, read_addr} !== {~pr[1], ~pr[0], e_ren, e_ra}) begin errors++;
        $display("FAIL rand_read%0d: got rdy=%b en=%b a=%0d want rdy=%b%b en=%b a=%0d", k,
                 ch_rd_ready, read_en, read_addr, ~pr[1], ~pr[0], e_ren, e_ra); end
      checks++; if ({ch_rsp_valid, ch_rsp_data} !== {m_rsp_v, m_rsp_d}) begin errors++;
        $display("FAIL rand_rsp%0d: got v=%b d=%b want v=%b d=%b", k, ch_rsp_valid, ch_rsp_data, m_rsp_v, m_rsp_d); end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_write();
    test_alternate();
    test_backpressure();
    test_read();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dut_port_arbiter.md
DUT_PORT_ARBITER -- requirements
Module: dut_port_arbiter

Interface
REQ-001 Parameter: NUM_CH, 2, number of requester channels (only 2 supported).
REQ-002 Parameter: ADDR_W, 3, DUT register address width.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ch_wr_valid  in  2  per-channel write request valid (bit i = channel i).
REQ-007 ch_wr_ready  out  2  per-channel write request accepted.
REQ-008 ch_wr_addr  in  6  {ch1,ch0} write addresses, 3 bits each.
REQ-009 ch_wr_data  in  2  per-channel write data bit.
REQ-010 ch_rd_valid  in  2  per-channel read request valid.
REQ-011 ch_rd_ready  out  2  per-channel read request accepted.
REQ-012 ch_rd_addr  in  6  {ch1,ch0} read addresses.
REQ-013 ch_rsp_valid  out  2  one-cycle read response strobe per channel.
REQ-014 ch_rsp_data  out  2  read response data per channel.
REQ-015 write_addr, write_data, write_en  out  3/1/1  DUT write port.
REQ-016 write_ready  in  1  DUT write port ready.
REQ-017 read_addr, read_en  out  3/1  DUT read port.
REQ-018 read_data, read_ready  in  1/1  DUT read data and ready.

Function
REQ-019 Each channel SHALL own a one-entry write buffer and a one-entry read buffer.
REQ-020 ch_wr_ready[i] SHALL equal the registered ~wbuf_full[i]; a request is accepted on ch_wr_valid[i] & ch_wr_ready[i].
REQ-021 ch_rd_ready[i] SHALL equal the registered ~rbuf_full[i].
REQ-022 write_en SHALL be (wbuf_full != 0) & write_ready; it SHALL never assert while write_ready=0.
REQ-023 Write grant: if one buffer is full, grant it; if both, grant the channel other than wr_last.
REQ-024 write_addr/write_data SHALL reflect the granted buffer combinationally; both SHALL be 0 when no buffer is full.
REQ-025 On write_en, the granted buffer SHALL clear and wr_last SHALL take the granted index at the same edge.
REQ-026 Read issue SHALL mirror REQ-022..025 using read_ready, read_en, read_addr and a separate rd_last pointer.
REQ-027 On read_en for channel g, read_data SHALL be registered into ch_rsp_data[g] and ch_rsp_valid[g] SHALL pulse for exactly the next cycle.
REQ-028 Latency SHALL be: accept at edge T; issue in cycle T+1 at the earliest; ch_rsp_valid in cycle T+2. Sustained per-channel throughput is 1 request per 2 cycles.
REQ-029 Write and read arbitration SHALL be independent; a write and a read may issue in the same cycle.
REQ-030 No response backpressure; ch_rsp_data[i] SHALL hold its value until the next response on that channel.
REQ-031 Acceptance of a new request into a buffer that is clearing in the same cycle SHALL NOT occur, because ready is registered-empty only.

Reset
REQ-032 While reset=1: all buffers empty, ch_wr_ready=ch_rd_ready=2'b11, write_en=read_en=0, ch_rsp_valid=0, ch_rsp_data=0, and all DUT address/data outputs 0.
REQ-033 wr_last and rd_last SHALL reset to 1, so channel 0 wins the first contention.
REQ-034 Reset asserted mid-operation SHALL discard buffered requests with no DUT enable issued.

Structure
REQ-035 Package dut_arb_pkg SHALL hold NUM_CH, ADDR_W, and the channel-index type.
REQ-036 Sub-module rr_arb2 (2-way round-robin picker: req[1:0], last -> gnt index, any) SHALL be instantiated twice, once for write and once for read.

Verification
REQ-037 Reset: reset=1 -> all outputs 0 except ch_wr_ready=ch_rd_ready=2'b11.
REQ-038 ch0 write addr 4 data 1 at T, write_ready=1 -> write_en=1, write_addr=4, write_data=1 in cycle T+1 only.
REQ-039 Both channels continuously write (ch0 addr 4 d1, ch1 addr 5 d0) -> grants ch0, ch1, ch0, ch1; no request lost.
REQ-040 Hold write_ready=0 for 5 cycles with both buffers full -> write_en=0, ch_wr_ready=2'b00 throughout; on release, ch0 issues first.
REQ-041 ch1 read addr 3 at T with read_data=1 -> read_en and read_addr=3 in cycle T+1; ch_rsp_valid=2'b10 and ch_rsp_data[1]=1 in cycle T+2.
REQ-042 Assert reset with both write buffers full and write_ready=0 -> buffers cleared, ch_wr_ready=2'b11, no write_en after release.
